relogio_display_7seg: RTL

- Display stage directly downstream of the debounced clock/adjust top. Consumes binary horas/minutos/segundos and modo_ajuste.
- Drives a multiplexed 8-digit, common-anode, active-low 7-segment display as HH.MM.SS.
- Shows the adjust mode on digit 7.
- Blinks the field currently being adjusted.

---
 rtl/relogio_display_7seg_pkg.sv | 40 ++++
 rtl/relogio_display_7seg_seg7_decoder.sv | 29 ++
 rtl/relogio_display_7seg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/relogio_display_7seg_pkg.sv
// Shared types and constants for the HH.MM.SS multiplexed 7-segment display stage.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package relogio_pkg;

    typedef enum logic [1:0] {
        MODO_RUN   = 2'd0,
        MODO_HORAS = 2'd1,
        MODO_MIN   = 2'd2,
        MODO_SEG   = 2'd3
    } modo_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit positions, right to left on the display
    localparam logic [2:0] DIG_SEG_U = 3'd0;
    localparam logic [2:0] DIG_SEG_D = 3'd1;
    localparam logic [2:0] DIG_MIN_U = 3'd2;
    localparam logic [2:0] DIG_MIN_D = 3'd3;
    localparam logic [2:0] DIG_HOR_U = 3'd4;
    localparam logic [2:0] DIG_HOR_D = 3'd5;
    localparam logic [2:0] DIG_VAZIO = 3'd6;
    localparam logic [2:0] DIG_MODO  = 3'd7;

    typedef struct packed {
        logic [3:0] dezena;
        logic [3:0] unidade;
    } bcd_t;

    // Splits a 6-bit binary value (0..63) into tens and units
    function automatic bcd_t bcd_split(input logic [5:0] valor);
        bcd_t r;
        r.dezena  = 4'(valor / 6'd10);
        r.unidade = 4'(valor % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/relogio_display_7seg_seg7_decoder.sv
// Decimal digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; codes above 9 blank.
// Latency: purely combinational.
// Backpressure: none.
module seg7_decoder
    import relogio_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] seg
);

    // Fixed lookup of the ten decimal glyphs
    always_comb begin
        seg = SEG_BLANK;
        case (digito)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/relogio_display_7seg.sv
// Scans an 8-digit common-anode display as HH.MM.SS plus adjust mode, blinking the field being adjusted.
// Latency: outputs follow the selected digit one cycle after each scan tick; a frame uses one input snapshot.
// Backpressure: none; inputs are sampled once per frame and the display free-runs.
module relogio_display_7seg
    import relogio_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [5:0] horas_i,
    input  logic [5:0] minutos_i,
    input  logic [5:0] segundos_i,
    input  logic [1:0] modo_ajuste_i,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic          scan_tick;
    logic [2:0]    digit_idx;
    logic          ativo;        // set by the first tick; keeps the display dark until then
    logic          captura;

    logic [5:0]    snap_horas;
    logic [5:0]    snap_min;
    logic [5:0]    snap_seg;
    modo_t         snap_modo;

    logic [1:0]    modo_q;
    logic          modo_mudou;
    logic [BW-1:0] blink_cnt;
    logic          blink_vis;

    bcd_t          bcd_h;
    bcd_t          bcd_m;
    bcd_t          bcd_s;
    logic          h_inval;
    logic          m_inval;
    logic          s_inval;

    logic [3:0]    dig;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          dash;
    logic          vazio;
    modo_t         campo;

    assign scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));
    // Capture on the very first tick and on every 7->0 wrap, so a whole frame shares one snapshot
    assign captura    = scan_tick && (!ativo || (digit_idx == DIG_MODO));
    assign modo_mudou = (modo_ajuste_i != modo_q);

    // Digit-slot timebase
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scan_cnt <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Digit sequencing; the first tick only starts the display at digit 0
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ativo     <= 1'b0;
            digit_idx <= 3'd0;
        end else if (scan_tick) begin
            ativo <= 1'b1;
            if (ativo) begin
                digit_idx <= digit_idx + 3'd1;
            end
        end
    end

    // Frame snapshot of the time and mode inputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            snap_horas <= '0;
            snap_min   <= '0;
            snap_seg   <= '0;
            snap_modo  <= MODO_RUN;
        end else if (captura) begin
            snap_horas <= horas_i;
            snap_min   <= minutos_i;
            snap_seg   <= segundos_i;
            snap_modo  <= modo_t'(modo_ajuste_i);
        end
    end

    // Blink phase; a mode change restarts it visible so the new field shows at once
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            modo_q    <= 2'd0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else begin
            modo_q <= modo_ajuste_i;
            if (modo_mudou) begin
                blink_cnt <= '0;
                blink_vis <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign bcd_h   = bcd_split(snap_horas);
    assign bcd_m   = bcd_split(snap_min);
    assign bcd_s   = bcd_split(snap_seg);
    assign h_inval = (snap_horas > 6'd23);
    assign m_inval = (snap_min   > 6'd59);
    assign s_inval = (snap_seg   > 6'd59);

    seg7_decoder u_dec (
        .digito (dig),
        .seg    (seg_dec)
    );

    // Select the digit value for the current slot, then apply blank/dash/blink overrides
    always_comb begin
        dig   = 4'd0;
        dash  = 1'b0;
        vazio = 1'b0;
        campo = MODO_RUN;
        case (digit_idx)
            DIG_SEG_U: begin dig = bcd_s.unidade; dash = s_inval; campo = MODO_SEG;   end
            DIG_SEG_D: begin dig = bcd_s.dezena;  dash = s_inval; campo = MODO_SEG;   end
            DIG_MIN_U: begin dig = bcd_m.unidade; dash = m_inval; campo = MODO_MIN;   end
            DIG_MIN_D: begin dig = bcd_m.dezena;  dash = m_inval; campo = MODO_MIN;   end
            DIG_HOR_U: begin dig = bcd_h.unidade; dash = h_inval; campo = MODO_HORAS; end
            DIG_HOR_D: begin dig = bcd_h.dezena;  dash = h_inval; campo = MODO_HORAS; end
            DIG_VAZIO: vazio = 1'b1;
            default:   dig = {2'b00, snap_modo};
        endcase

        if (vazio || ((snap_modo != MODO_RUN) && !blink_vis && (campo == snap_modo))) begin
            seg_nxt = SEG_BLANK;
        end else if (dash) begin
            seg_nxt = SEG_DASH;
        end else begin
            seg_nxt = seg_dec;
        end

        dp_nxt = !((digit_idx == DIG_MIN_U) || (digit_idx == DIG_HOR_U));
    end

    // Registered display drive; dark until the scan has started
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            an_o  <= 8'hFF;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end else if (ativo) begin
            an_o  <= ~(8'd1 << digit_idx);
            seg_o <= seg_nxt;
            dp_o  <= dp_nxt;
        end else begin
            an_o  <= 8'hFF;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end
    end

endmodule
